// File: rtl/ase_reorder_pkg.sv
// Shared definitions for the latency reorder buffer: tag width derivation,
// default payload widths and the {meta, data} slot record.
package ase_reorder_pkg;

  localparam int unsigned DEF_NUM_TRANSACTIONS = 4;
  localparam int unsigned DEF_HDR_WIDTH        = 72;
  localparam int unsigned DEF_DATA_WIDTH       = 72;

  // Tag width for a slot count; a single-slot buffer still needs one tag bit.
  function automatic int unsigned tag_width(input int unsigned num_slots);
    return (num_slots < 2) ? 1 : $clog2(num_slots);
  endfunction

  // One stored response at the default widths.
  typedef struct packed {
    logic [DEF_HDR_WIDTH-1:0]  meta;
    logic [DEF_DATA_WIDTH-1:0] data;
  } reorder_slot_t;

endpackage

// File: rtl/reorder_slot_ram.sv
// Slot storage for the reorder buffer: simple dual-port memory written by
// response tag and read asynchronously at the head pointer. Not reset.
// Ports:
//   clk      - clock
//   wr_en    - store wr_data at wr_addr on this edge
//   wr_addr  - slot index (response tag)
//   wr_data  - {meta, data} record
//   rd_addr  - slot index to read (head pointer)
//   rd_data  - contents of rd_addr, combinational
module reorder_slot_ram #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned WIDTH      = 144,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Asynchronous read port.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/latency_reorder_buffer.sv
// Latency reorder buffer: grants tags in issue order, accepts responses by
// tag in any order and releases {meta, data} strictly in allocation order
// through a pop-style read interface.
// Optional feature macro: LATENCY_REORDER_CHECK_EN rejects stray and
// duplicate responses (rsp_err pulse plus simulation $error); without it
// every response is stored and rsp_err is tied low.
// Ports:
//   clk, rst                - clock, synchronous active-high reset
//   alloc_valid / alloc_tag - allocate request / tag granted (tail pointer)
//   rsp_valid, rsp_tag,
//   rsp_meta, rsp_data      - response by tag
//   meta_out, data_out,
//   valid_out, read_en      - head slot contents, head filled, pop head
//   empty, full             - outstanding allocation status
//   overflow, underflow     - sticky misuse flags
//   rsp_err                 - one-cycle pulse for a rejected response
module latency_reorder_buffer
  import ase_reorder_pkg::*;
#(
  parameter  int unsigned NUM_TRANSACTIONS = DEF_NUM_TRANSACTIONS,
  parameter  int unsigned HDR_WIDTH        = DEF_HDR_WIDTH,
  parameter  int unsigned DATA_WIDTH       = DEF_DATA_WIDTH,
  localparam int unsigned TAG_WIDTH        = tag_width(NUM_TRANSACTIONS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  output logic [TAG_WIDTH-1:0]  alloc_tag,
  input  logic                  rsp_valid,
  input  logic [TAG_WIDTH-1:0]  rsp_tag,
  input  logic [HDR_WIDTH-1:0]  rsp_meta,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  output logic [HDR_WIDTH-1:0]  meta_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  read_en,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  rsp_err
);

  localparam int unsigned SLOT_WIDTH  = HDR_WIDTH + DATA_WIDTH;
  localparam int unsigned COUNT_WIDTH = TAG_WIDTH + 1;

  logic [NUM_TRANSACTIONS-1:0] alloc_q, alloc_d;
  logic [NUM_TRANSACTIONS-1:0] filled_q, filled_d;
  logic [TAG_WIDTH-1:0]        head_q, tail_q;
  logic [COUNT_WIDTH-1:0]      count_q, count_d;
  logic                        alloc_fire, pop_fire, rsp_ok;
  logic [SLOT_WIDTH-1:0]       head_word;

  // Status decoded from registers only.
  assign full      = (count_q == COUNT_WIDTH'(NUM_TRANSACTIONS));
  assign empty     = (count_q == '0);
  assign valid_out = filled_q[head_q];
  assign alloc_tag = tail_q;

  assign alloc_fire = alloc_valid && !full;
  assign pop_fire   = read_en && valid_out;

`ifdef LATENCY_REORDER_CHECK_EN
  // Only an allocated, not yet answered tag may take a response.
  assign rsp_ok = rsp_valid && alloc_q[rsp_tag] && !filled_q[rsp_tag];

  // Rejection pulse, visible the cycle after the offending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_err <= 1'b0;
    end else begin
      rsp_err <= rsp_valid && !rsp_ok;
      if (rsp_valid && !rsp_ok) begin
        $error("latency_reorder_buffer: rejected response for tag %0d", rsp_tag);
      end
    end
  end
`else
  assign rsp_ok  = rsp_valid;
  assign rsp_err = 1'b0;
`endif

  // Next slot bits and occupancy. Pop is applied last so a popped slot is
  // always left fully cleared.
  always_comb begin
    alloc_d  = alloc_q;
    filled_d = filled_q;
    count_d  = count_q;
    if (rsp_ok) begin
      filled_d[rsp_tag] = 1'b1;
    end
    if (alloc_fire) begin
      alloc_d[tail_q] = 1'b1;
    end
    if (pop_fire) begin
      alloc_d[head_q]  = 1'b0;
      filled_d[head_q] = 1'b0;
    end
    case ({alloc_fire, pop_fire})
      2'b10:   count_d = count_q + COUNT_WIDTH'(1);
      2'b01:   count_d = count_q - COUNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_q   <= '0;
      filled_q  <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      alloc_q   <= alloc_d;
      filled_q  <= filled_d;
      count_q   <= count_d;
      if (alloc_fire) begin
        tail_q <= tail_q + TAG_WIDTH'(1);
      end
      if (pop_fire) begin
        head_q <= head_q + TAG_WIDTH'(1);
      end
      overflow  <= overflow  | (alloc_valid && full);
      underflow <= underflow | (read_en && !valid_out);
    end
  end

  reorder_slot_ram #(
    .DEPTH      (NUM_TRANSACTIONS),
    .WIDTH      (SLOT_WIDTH),
    .ADDR_WIDTH (TAG_WIDTH)
  ) u_slot_ram (
    .clk     (clk),
    .wr_en   (rsp_ok),
    .wr_addr (rsp_tag),
    .wr_data ({rsp_meta, rsp_data}),
    .rd_addr (head_q),
    .rd_data (head_word)
  );

  assign {meta_out, data_out} = head_word;

endmodule

// File: tb/tb_latency_reorder_buffer.sv
// Directed bench for latency_reorder_buffer with hand-computed expectations.
module tb_latency_reorder_buffer;

  localparam int unsigned TW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_valid;
  logic [TW-1:0] alloc_tag;
  logic          rsp_valid;
  logic [TW-1:0] rsp_tag;
  logic [71:0]   rsp_meta;
  logic [71:0]   rsp_data;
  logic [71:0]   meta_out;
  logic [71:0]   data_out;
  logic          valid_out;
  logic          read_en;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;
  logic          rsp_err;

  int n_vec = 0;
  int n_err = 0;

  latency_reorder_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (alloc_valid),
    .alloc_tag   (alloc_tag),
    .rsp_valid   (rsp_valid),
    .rsp_tag     (rsp_tag),
    .rsp_meta    (rsp_meta),
    .rsp_data    (rsp_data),
    .meta_out    (meta_out),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .read_en     (read_en),
    .empty       (empty),
    .full        (full),
    .overflow    (overflow),
    .underflow   (underflow),
    .rsp_err     (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then settled and inputs may change.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid = 1'b0;
    rsp_valid   = 1'b0;
    rsp_tag     = '0;
    rsp_meta    = '0;
    rsp_data    = '0;
    read_en     = 1'b0;
  endtask

  task automatic respond(input int tag, input logic [71:0] meta, input logic [71:0] data);
    rsp_valid = 1'b1;
    rsp_tag   = TW'(tag);
    rsp_meta  = meta;
    rsp_data  = data;
    tick();
    rsp_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [71:0] mk_meta(input int k);
    return {8'(k), 64'h0};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          ord [4];
    bit          seen0;
    logic        flags_seen;
    int          tag_q [$];
    int          seq_q [$];
    int          n_alloc;
    int          n_pop;
    int          first_pop;
    int          last_pop;
    int          s;

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    chk("rst_empty", 72'(empty), 72'd1);
    chk("rst_full", 72'(full), 72'd0);
    chk("rst_valid_out", 72'(valid_out), 72'd0);
    chk("rst_alloc_tag", 72'(alloc_tag), 72'd0);

    // Idle: no flag may rise.
    flags_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      flags_seen = flags_seen | overflow | underflow | rsp_err | valid_out;
    end
    chk("idle_flags", 72'(flags_seen), 72'd0);

    // Allocate 0..3, respond 3,1,0,2, drain in order.
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1'b1;
      chk("alloc_tag_seq", 72'(alloc_tag), 72'(i));
      tick();
    end
    alloc_valid = 1'b0;
    chk("full_after_4", 72'(full), 72'd1);
    chk("empty_after_4", 72'(empty), 72'd0);
    ord   = '{3, 1, 0, 2};
    seen0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      respond(ord[i], mk_meta(ord[i] + 1), 72'(72'hD0 + ord[i]));
      if (ord[i] == 0) seen0 = 1'b1;
      chk("ooo_valid_out", 72'(valid_out), 72'(seen0));
    end
    for (int i = 0; i < 4; i++) begin
      chk("ooo_valid", 72'(valid_out), 72'd1);
      chk("ooo_meta", meta_out, mk_meta(i + 1));
      chk("ooo_data", data_out, 72'(72'hD0 + i));
      read_en = 1'b1;
      tick();
      read_en = 1'b0;
    end
    chk("ooo_empty", 72'(empty), 72'd1);
    chk("ooo_valid_end", 72'(valid_out), 72'd0);
    chk("ooo_underflow", 72'(underflow), 72'd0);

    // Overflow: tail is back at 0; fill, then one extra allocate.
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1'b1;
      tick();
    end
    alloc_valid = 1'b1;
    tick();
    alloc_valid = 1'b0;
    chk("ovf_flag", 72'(overflow), 72'd1);
    chk("ovf_tail", 72'(alloc_tag), 72'd0);
    chk("ovf_full", 72'(full), 72'd1);
    respond(0, mk_meta(7), 72'h77);
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    chk("ovf_pop_full", 72'(full), 72'd0);
    chk("ovf_reuse_tag", 72'(alloc_tag), 72'd0);
    alloc_valid = 1'b1;
    tick();
    alloc_valid = 1'b0;
    chk("ovf_refull", 72'(full), 72'd1);
    chk("ovf_tail_adv", 72'(alloc_tag), 72'd1);
    tick();
    chk("ovf_sticky", 72'(overflow), 72'd1);

    // Reset mid-operation discards everything.
    do_reset();
    chk("mid_rst_ovf", 72'(overflow), 72'd0);
    chk("mid_rst_empty", 72'(empty), 72'd1);
    chk("mid_rst_valid", 72'(valid_out), 72'd0);
    chk("mid_rst_tag", 72'(alloc_tag), 72'd0);

    // Streaming: allocate each cycle, respond in order next cycle, pop when valid.
    n_alloc   = 0;
    n_pop     = 0;
    first_pop = -1;
    last_pop  = -1;
    for (int cyc = 0; cyc < 60 && n_pop < 10; cyc++) begin
      idle_inputs();
      if (valid_out) begin
        chk("stream_meta", meta_out, mk_meta(n_pop + 1));
        chk("stream_data", data_out, 72'(72'hA00 + n_pop));
        read_en = 1'b1;
        n_pop++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      if (tag_q.size() > 0) begin
        s         = seq_q.pop_front();
        rsp_valid = 1'b1;
        rsp_tag   = TW'(tag_q.pop_front());
        rsp_meta  = mk_meta(s + 1);
        rsp_data  = 72'(72'hA00 + s);
      end
      if (n_alloc < 10 && !full) begin
        alloc_valid = 1'b1;
        tag_q.push_back(int'(alloc_tag));
        seq_q.push_back(n_alloc);
        n_alloc++;
      end
      tick();
    end
    idle_inputs();
    chk("stream_pops", 72'(n_pop), 72'd10);
    chk("stream_rate", 72'(last_pop - first_pop), 72'd9);
    chk("stream_empty", 72'(empty), 72'd1);
    chk("stream_underflow", 72'(underflow), 72'd0);

    // Underflow: head is slot 2 after ten transactions.
    alloc_valid = 1'b1;
    tick();
    alloc_valid = 1'b0;
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    chk("udf_flag", 72'(underflow), 72'd1);
    chk("udf_tail", 72'(alloc_tag), 72'd3);
    chk("udf_count", 72'(empty), 72'd0);
    chk("udf_valid", 72'(valid_out), 72'd0);
    // Response to head together with read_en: stored, not popped.
    read_en = 1'b1;
    respond(2, mk_meta(9), 72'h99);
    read_en = 1'b0;
    chk("udf_same_valid", 72'(valid_out), 72'd1);
    chk("udf_same_meta", meta_out, mk_meta(9));
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    chk("udf_drain_empty", 72'(empty), 72'd1);
    chk("udf_sticky", 72'(underflow), 72'd1);

`ifdef LATENCY_REORDER_CHECK_EN
    // Stray and duplicate responses are rejected.
    do_reset();
    respond(2, mk_meta(3), 72'h33);
    chk("stray_err", 72'(rsp_err), 72'd1);
    tick();
    chk("stray_err_pulse", 72'(rsp_err), 72'd0);
    chk("stray_not_stored", 72'(valid_out), 72'd0);
    alloc_valid = 1'b1;
    tick();
    alloc_valid = 1'b0;
    respond(0, mk_meta(5), 72'h55);
    chk("first_rsp_ok", 72'(rsp_err), 72'd0);
    respond(0, mk_meta(6), 72'h66);
    chk("dup_err", 72'(rsp_err), 72'd1);
    chk("dup_kept_meta", meta_out, mk_meta(5));
    chk("dup_kept_data", data_out, 72'h55);
`else
    chk("no_check_err", 72'(rsp_err), 72'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
